fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the 16-bit CPU. It owns the program counter and drives the combinational instruction memory address. Fetched words go into a small prefetch queue, and the queue presents instructions, with their PCs, to the decode stage (control/aluctrl/regfile) over a valid/ready handshake. Jumps and taken branches resolved downstream redirect the PC and flush the queue.

## Interface
- RESET_PC, 16'h0000: PC value loaded on reset.
- DEPTH, 2: prefetch queue entries. Legal values are 2 or 4.

- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  16  instruction memory address; equals the internal fetch PC (fpc), combinationally.
- imem_data  in  16  instruction word returned combinationally by imem for imem_addr.
- redirect  in  1  jump or taken branch; valid for one cycle.
- redirect_pc  in  16  target PC; sampled when redirect=1.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head this cycle.
- inst  out  16  head instruction word. Format: opcode[15:13], wreg[12:10], reg1[9:7], reg2[6:4], func[3:0].
- inst_pc  out  16  address of the head instruction.
- halted  out  1  fetch stopped on a halt word (see Configuration).

## Operation
- State:
  - fpc (16 bits).
  - Circular queue of DEPTH entries, each {pc, word}.
  - Read pointer, write pointer and count (count width clog2(DEPTH)+1).
  - halt flag.
- pop = inst_valid & inst_ready.
- push = !redirect & !halted & (count < DEPTH | pop).
- On push:
  - Enqueue {fpc, imem_data}.
  - fpc <= fpc + 1, modulo 2^16; 16'hFFFF wraps to 16'h0000.
- On pop: advance the read pointer and decrement count.
- Simultaneous push and pop:
  - count is unchanged.
  - This is legal when the queue is full.
- On redirect:
  - The pop handshake in that cycle still completes.
  - Then all entries are flushed (count <= 0, pointers reset).
  - fpc <= redirect_pc, the halt flag clears, and no push occurs that cycle.
- Outputs:
  - inst_valid = (count != 0).
  - inst and inst_pc show the head entry while inst_valid=1, and are driven 16'h0000 while inst_valid=0.
- The queue never drops or duplicates an entry except through flush.
- With inst_ready held low, the queue fills to DEPTH and fpc holds. imem_addr stays stable while fpc holds.

## Timing
- Reset values, effective immediately on rst_n low and independent of clk:
  - fpc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, inst_valid = 0, inst = 0, inst_pc = 0, halted = 0.
- First edge after rst_n deasserts: pushes the word at RESET_PC, so inst_valid=1 one cycle after reset release.
- Steady state (inst_ready=1 continuously): one instruction per cycle; consecutive inst_pc values differ by 1.
- Redirect latency:
  - Edge N samples redirect=1, and inst_valid=0 during cycle N+1.
  - Edge N+1 pushes the word at redirect_pc, which is visible with inst_valid=1 in cycle N+2.
- A redirect while the queue is empty, full, or halted behaves identically.
- A redirect asserted on consecutive cycles: the last one wins.
- rst_n asserted mid-operation aborts everything immediately; no partial entry survives.

## Configuration
- Macro: FETCH_HALT_EN.
- Defined:
  - A pushed word equal to 16'hFFFF is enqueued normally.
  - The halt flag sets on that same edge, and halted=1 from the next cycle.
  - Pushes then stop. Remaining entries still drain through the handshake.
  - Only redirect or reset clears halted.
- Undefined:
  - 16'hFFFF is an ordinary instruction.
  - halted is tied to 0, and no halt logic is synthesised.

## Test plan
- Reset/stream:
  - Stimulus: imem holds word = 16'h1000+addr; release rst_n; keep inst_ready=1.
  - Required: inst_valid rises after the first edge; the inst/inst_pc sequence is 16'h1000/0, 16'h1001/1, 16'h1002/2, …, with no gaps.
- Backpressure (DEPTH=2):
  - Stimulus: hold inst_ready=0 for 5 cycles, then 1.
  - Required: count saturates at 2, imem_addr holds at 2, and entries pc0 and pc1 are then delivered in order followed by pc2, with nothing lost or duplicated.
- Redirect:
  - Stimulus: assert redirect with redirect_pc=16'h0040 while the queue is full.
  - Required: inst_valid=0 in the next cycle; the following cycle shows inst_pc=16'h0040 with the word at 0x40; the flushed entries never appear.
- Wrap:
  - Stimulus: redirect to 16'hFFFE.
  - Required: inst_pc sequence FFFE, FFFF, 0000, 0001.
- Halt (FETCH_HALT_EN defined):
  - Stimulus: a halt word 16'hFFFF at address 3.
  - Required: addresses 0–3 are delivered, halted=1, and imem_addr freezes at 4. A later redirect to 0 clears halted and fetch resumes at 0.
  - Stimulus: the same program with the macro undefined.
  - Required: address 4 is fetched normally and halted stays 0.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while the queue holds 2 entries.
  - Required: inst_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fills a small prefetch queue and hands {pc, word} to decode.
// Optional feature: define FETCH_HALT_EN to stop fetching after a 16'hFFFF halt word.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic        halted
);

    localparam int unsigned XLEN  = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0] HALT_WORD = 16'hFFFF;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } entry_t;

    logic [XLEN-1:0]  fpc_q, fpc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic             halt_q;
    logic             pop;
    logic             push;

`ifdef FETCH_HALT_EN
    logic             halt_d;
`else
    assign halt_q = 1'b0;
`endif

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = ~redirect & ~halt_q & ((count_q < CNT_W'(DEPTH)) | pop);

    assign imem_addr  = fpc_q;
    assign inst       = inst_valid ? mem_q[rd_ptr_q].word : '0;
    assign inst_pc    = inst_valid ? mem_q[rd_ptr_q].pc   : '0;
    assign halted     = halt_q;

    // Next-state: enqueue/dequeue, then a redirect overrides with a full flush.
    always_comb begin
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
`ifdef FETCH_HALT_EN
        halt_d   = halt_q;
`endif

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{pc: fpc_q, word: imem_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            fpc_d           = fpc_q + XLEN'(1);
`ifdef FETCH_HALT_EN
            if (imem_data == HALT_WORD) begin
                halt_d = 1'b1;
            end
`endif
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            fpc_d    = redirect_pc;
`ifdef FETCH_HALT_EN
            halt_d   = 1'b0;
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        halted;

    int total = 0;
    int bad   = 0;

    logic        halt_prog;
    ent_t        mq[$];
    logic [15:0] m_fpc;
    logic        m_halt;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a, input logic hp);
        if (hp && a == 16'd3) return 16'hFFFF;
        return 16'h1000 + a;
    endfunction

    always_comb imem_data = rom(imem_addr, halt_prog);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc  = RESET_PC;
        m_halt = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare, advance the model across the posedge.
    task automatic cycle(input logic rdy, input logic rd, input logic [15:0] rpc);
        logic        p_pop;
        logic        p_push;
        logic [15:0] w;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        chk("inst_valid", 16'(inst_valid), 16'(mq.size() != 0));
        chk("inst", inst, (mq.size() != 0) ? mq[0].word : 16'h0000);
        chk("inst_pc", inst_pc, (mq.size() != 0) ? mq[0].pc : 16'h0000);
        chk("imem_addr", imem_addr, m_fpc);
        chk("halted", 16'(halted), 16'(m_halt));
        p_pop  = (mq.size() != 0) && rdy;
        p_push = !rd && !m_halt && ((mq.size() < int'(DEPTH)) || p_pop);
        w      = rom(m_fpc, halt_prog);
        @(posedge clk);
        if (p_pop) void'(mq.pop_front());
        if (p_push) begin
            mq.push_back('{pc: m_fpc, word: w});
            m_fpc = m_fpc + 16'd1;
            if (HALT_EN && w == 16'hFFFF) m_halt = 1'b1;
        end
        if (rd) begin
            mq.delete();
            m_fpc  = rpc;
            m_halt = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        inst_ready  = 1'b0;
        halt_prog   = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 16'(inst_valid), 16'h0000);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_pc", inst_pc, 16'h0000);
        chk("rst_halted", 16'(halted), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with decode always ready.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'h0);

        // Backpressure: queue saturates, fpc holds, then drains in order.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0);

        // Redirect while full.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0040);
        chk("redir_flush", 16'(inst_valid), 16'h0000);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0);

        // PC wrap.
        cycle(1'b1, 1'b1, 16'hFFFE);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0);

        // Halt word at address 3.
        halt_prog = 1'b1;
        cycle(1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'h0);
        if (HALT_EN) begin
            chk("halt_flag", 16'(halted), 16'h0001);
            chk("halt_addr", imem_addr, 16'h0004);
        end else begin
            chk("nohalt_flag", 16'(halted), 16'h0000);
        end
        cycle(1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0);

        // Randomized handshake and redirect traffic.
        for (int i = 0; i < 300; i++) begin
            logic        r_rdy;
            logic        r_rd;
            logic [15:0] r_pc;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rd  = ($urandom_range(0, 9) == 0);
            r_pc  = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom_range(0, 12));
            cycle(r_rdy, r_rd, r_pc);
        end
        halt_prog = 1'b0;

        // Asynchronous reset mid-cycle with two entries queued.
        cycle(1'b0, 1'b1, 16'h0020);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0);
        chk("pre_rst_count", 16'(mq.size()), 16'(DEPTH));
        chk("pre_rst_valid", 16'(inst_valid), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 16'(inst_valid), 16'h0000);
        chk("arst_addr", imem_addr, RESET_PC);
        chk("arst_inst", inst, 16'h0000);
        chk("arst_pc", inst_pc, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
